// File: rtl/pwmin_pkg.sv
// -----------------------------------------------------------------------------
// pwmin_pkg
// Shared definitions for the PWM input capture block.
//   pwmin_state_e : per-channel measurement state
//                   WAIT - no reference rise yet (after reset or a timeout)
//                   MEAS - a rise has been seen, the cycle counter is running
//   FILT_CNT_W    : width of the glitch-filter run counter; wide enough for
//                   FILTER values up to 15
// -----------------------------------------------------------------------------
package pwmin_pkg;

  typedef enum logic {
    WAIT = 1'b0,
    MEAS = 1'b1
  } pwmin_state_e;

  localparam int unsigned FILT_CNT_W = 4;

endpackage : pwmin_pkg

// File: rtl/pwmin_channel.sv
// -----------------------------------------------------------------------------
// pwmin_channel
// One PWM input measurement channel.
//
// The raw input is synchronised with two flops, optionally inverted, and then
// passed through a run-length filter. The filter accepts a new level only after
// FILTER consecutive samples disagree with the current level. Rises and falls
// of the filtered level drive a two-state measurement FSM. That FSM counts clk
// cycles between rises (period) and from a rise to the following fall (high).
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   sig_i     in   raw asynchronous PWM input
//   period_o  out  last measured period in clk cycles
//   high_o    out  high time of the same PWM cycle in clk cycles
//   valid_o   out  period_o/high_o hold a complete measurement
//   level_o   out  filtered (and optionally inverted) input level
//   state_o   out  current FSM state, for debug visibility
// -----------------------------------------------------------------------------
module pwmin_channel
  import pwmin_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned FILTER  = 2,
  parameter int unsigned TIMEOUT = (2**WIDTH) - 1,
  parameter bit          INVERT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_i,
  output logic [WIDTH-1:0] period_o,
  output logic [WIDTH-1:0] high_o,
  output logic             valid_o,
  output logic             level_o,
  output pwmin_state_e     state_o
);

  localparam logic [WIDTH-1:0]      TIMEOUT_CNT = WIDTH'(TIMEOUT);
  localparam logic [FILT_CNT_W-1:0] FILT_LAST   = FILT_CNT_W'(FILTER - 1);
  localparam logic [WIDTH-1:0]      CNT_ONE     = WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Synchroniser and filter state
  // ---------------------------------------------------------------------------
  logic [1:0]            sync_q;
  logic                  sample;
  logic                  level_q;
  logic                  level_d;
  logic [FILT_CNT_W-1:0] run_q;
  logic [FILT_CNT_W-1:0] run_d;
  logic                  rise;
  logic                  fall;

  // ---------------------------------------------------------------------------
  // Measurement state
  // ---------------------------------------------------------------------------
  pwmin_state_e     state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] hlat_q;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] high_q;
  logic             valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      run_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], sig_i};
      level_q <= level_d;
      run_q   <= run_d;
    end
  end

  // The run counter counts disagreeing samples. The FILTER-th disagreeing
  // sample flips the level in the same cycle, so the counter only has to
  // reach FILTER-1. Any agreeing sample restarts the run from zero.
  always_comb begin
    sample  = sync_q[1] ^ INVERT;
    level_d = level_q;
    run_d   = '0;
    if (sample != level_q) begin
      if (run_q == FILT_LAST) begin
        level_d = sample;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  // Edges are taken from the filtered level about to be registered. The FSM
  // therefore reacts on the same clk edge that makes the level change
  // visible on level_o. A single level bit cannot rise and fall at once.
  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  // ---------------------------------------------------------------------------
  // Measurement FSM
  // cnt_q is 1 on the edge that registers a rise and counts up from there.
  // The next rise therefore sees cnt_q equal to the number of cycles between
  // the two rises. It is bounded by TIMEOUT_CNT, which keeps it from wrapping.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT;
      cnt_q    <= '0;
      hlat_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        WAIT: begin
          // The first rise only opens a measurement window.
          if (rise) begin
            cnt_q   <= CNT_ONE;
            state_q <= MEAS;
          end
        end

        MEAS: begin
          if (fall) begin
            hlat_q <= cnt_q;
          end
          if (rise) begin
            // A rise wins over a simultaneous timeout.
            period_q <= cnt_q;
            high_q   <= hlat_q;
            valid_q  <= 1'b1;
            cnt_q    <= CNT_ONE;
          end else if (cnt_q == TIMEOUT_CNT) begin
            // Input stuck: drop the stale result and wait for a fresh rise.
            state_q  <= WAIT;
            cnt_q    <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= WAIT;
        end
      endcase
    end
  end

  assign period_o = period_q;
  assign high_o   = high_q;
  assign valid_o  = valid_q;
  assign level_o  = level_q;
  assign state_o  = state_q;

endmodule : pwmin_channel

// File: rtl/pwmin_capture.sv
// -----------------------------------------------------------------------------
// pwmin_capture
// Multi-channel PWM input capture. Each channel independently measures the
// period and high time of its PWM input in clk cycles. Each channel also
// reports its filtered level. Results are packed with channel i in bits
// [i*WIDTH +: WIDTH].
//
// Parameters
//   CHANNELS  number of independent channels (1..32)
//   WIDTH     width of period/high results
//   FILTER    consecutive stable samples needed to accept a level change (1..15)
//   TIMEOUT   cycles without a rise before a channel is invalidated
//             (2 .. 2**WIDTH-1)
//   INVERT    per-channel input inversion mask
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   SIGNAL    in   asynchronous PWM inputs, one bit per channel
//   period    out  packed last measured periods
//   high      out  packed high times of the same PWM cycles
//   valid     out  per-channel "measurement complete" flags
//   level     out  per-channel filtered input levels
//   dbg_meas  out  per-channel debug view of the FSM: 1 = MEAS, 0 = WAIT
// -----------------------------------------------------------------------------
module pwmin_capture
  import pwmin_pkg::*;
#(
  parameter int unsigned         CHANNELS = 4,
  parameter int unsigned         WIDTH    = 16,
  parameter int unsigned         FILTER   = 2,
  parameter int unsigned         TIMEOUT  = (2**WIDTH) - 1,
  parameter logic [CHANNELS-1:0] INVERT   = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       SIGNAL,
  output logic [CHANNELS*WIDTH-1:0] period,
  output logic [CHANNELS*WIDTH-1:0] high,
  output logic [CHANNELS-1:0]       valid,
  output logic [CHANNELS-1:0]       level,
  output logic [CHANNELS-1:0]       dbg_meas
);

  pwmin_state_e ch_state [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwmin_channel #(
      .WIDTH   (WIDTH),
      .FILTER  (FILTER),
      .TIMEOUT (TIMEOUT),
      .INVERT  (INVERT[i])
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .sig_i    (SIGNAL[i]),
      .period_o (period[i*WIDTH +: WIDTH]),
      .high_o   (high[i*WIDTH +: WIDTH]),
      .valid_o  (valid[i]),
      .level_o  (level[i]),
      .state_o  (ch_state[i])
    );

    assign dbg_meas[i] = (ch_state[i] == MEAS);
  end

endmodule : pwmin_capture

// File: doc/pwmin_capture.md
PWMIN_CAPTURE -- requirements
Module: pwmin_capture

Interface
REQ-001 Parameter CHANNELS, default 4, sets the number of independent PWM input channels (1..32).
REQ-002 Parameter WIDTH, default 16, sets the bit width of the period and high-time results.
REQ-003 Parameter FILTER, default 2, sets the consecutive stable samples needed to accept a level change (1..15).
REQ-004 Parameter TIMEOUT, default 2**WIDTH-1, sets the cycle count without a rising edge that invalidates a channel; it must satisfy 2 <= TIMEOUT <= 2**WIDTH-1.
REQ-005 Parameter INVERT, default 0, is a CHANNELS-bit mask; a set bit inverts that channel's input before filtering.
REQ-006 clk  input  1  single system clock; all logic on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 SIGNAL  input  CHANNELS  asynchronous PWM inputs, one bit per channel.
REQ-009 period  output  CHANNELS*WIDTH  last measured period per channel in clk cycles; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 high  output  CHANNELS*WIDTH  high time of the same cycle per channel in clk cycles, packed as period.
REQ-011 valid  output  CHANNELS  per channel, set when period and high hold a complete measurement.
REQ-012 level  output  CHANNELS  per channel, the filtered input level.

Function (per channel, channels fully independent)
REQ-013 SIGNAL shall pass through a 2-flop synchroniser and then through the INVERT XOR.
REQ-014 The filter shall change the filtered level only after FILTER consecutive synchronised samples differ from it; any sample equal to the current level shall clear the run counter.
REQ-015 A rise or fall shall be a change of the filtered level between consecutive cycles; rise and fall can never occur in the same cycle.
REQ-016 Edge latency shall be 2+FILTER cycles from a SIGNAL change to the level change, and outputs shall update on the clk edge that registers the rise.
REQ-017 The state machine shall have two states: WAIT (entered at reset and on timeout) and MEAS.
REQ-018 In WAIT, a rise shall set cnt to 1, enter MEAS, and leave period, high and valid unchanged.
REQ-019 In MEAS, cnt shall increment by 1 each cycle, and a fall shall latch hlat <= cnt.
REQ-020 In MEAS, a rise shall set period <= cnt and high <= hlat, set valid to 1 and cnt to 1, and remain in MEAS.
REQ-021 In MEAS, when cnt == TIMEOUT with no rise in that cycle, the channel shall enter WAIT and set valid to 0, period to 0 and high to 0; level continues to show the stuck level.
REQ-022 Because TIMEOUT <= 2**WIDTH-1, cnt shall never wrap.
REQ-023 A rise in the same cycle that cnt == TIMEOUT shall be treated as a normal rise under REQ-020 and shall not cause a timeout.
REQ-024 A rise with no fall since the previous rise cannot occur after filtering, so no error handling is required for it.

Reset
REQ-025 While rst_n=0, all registers shall clear: synchronisers and filtered level 0, state WAIT, cnt 0, hlat 0, period 0, high 0, valid 0.
REQ-026 Reset mid-measurement shall discard the measurement in progress, and the first rise after release shall only start a new measurement.

Structure
REQ-027 Package pwmin_pkg shall hold the state enum (WAIT, MEAS) and the filter-counter width constant.
REQ-028 One sub-module, pwmin_channel, shall implement a single channel (REQ-013..REQ-024); pwmin_capture shall generate CHANNELS instances and pack their outputs.

Verification
REQ-029 Defaults, SIGNAL[0] toggling every 50 clk -> after the second filtered rise, period[0]=100, high[0]=50, valid[0]=1; the values are stable on every later rise.
REQ-030 A 1-clk glitch on the high phase of a 30/70 PWM with FILTER=2 -> period=100 and high=30 unchanged; level shows no glitch.
REQ-031 Toggling stops with SIGNAL held at 1 and TIMEOUT=500 -> valid=0, period=0 and high=0 exactly 500 cycles after the last rise's cnt=1; level=1.
REQ-032 rst_n pulsed low mid-high-phase -> outputs are 0 immediately; the first rise after release gives no update and the second rise gives correct values.
REQ-033 CHANNELS=4 with periods 20/40/60/80 and INVERT=4'b0010 -> each channel reports its own period; channel 1's high equals the original low time.
REQ-034 WIDTH=8, TIMEOUT=255, period 255 -> period=255 with valid held at 1; period 256 -> timeout, valid=0.
